// File: rtl/matmul_sequencer.sv
// Sequences one LOAD (weights) or MATMUL (activations + result write-back) per command.
// Optional MATMUL_SEQ_PERF_EN adds a busy-cycle counter output.
module matmul_sequencer #(
  parameter int SA_LENGTH      = 10,
  parameter int UB_ADDR_WIDTH  = 4,
  parameter int UB_NO_BANKS    = 4,
  parameter int ROWS_WIDTH     = 8,
  parameter int RESULT_LATENCY = 2*SA_LENGTH,
  localparam int BW = UB_ADDR_WIDTH + $clog2(UB_NO_BANKS)
) (
  input  logic                  CLK,
  input  logic                  SYNC_RST,
  input  logic                  start,
  input  logic                  op,
  input  logic [BW-1:0]         src_addr,
  input  logic [BW-1:0]         dst_addr,
  input  logic [ROWS_WIDTH-1:0] rows,
  output logic                  busy,
  output logic                  done,
  output logic                  brden,
  output logic [BW-1:0]         brdaddr,
  output logic                  bwren,
  output logic [BW-1:0]         bwraddr,
  output logic                  sa_en,
  output logic                  sa_load
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  localparam int CW = (ROWS_WIDTH > $clog2(SA_LENGTH + 1)) ? ROWS_WIDTH : $clog2(SA_LENGTH + 1);
  localparam int DW = $clog2(RESULT_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    op_q;
  logic [CW-1:0]           len_q, rd_cnt;
  logic [DW-1:0]           drain_cnt, drain_last;
  logic [BW-1:0]           rd_addr, wr_addr;
  logic [RESULT_LATENCY:0] wr_pipe;

  assign accept     = (state == IDLE) && start;
  assign drain_last = op_q ? DW'(RESULT_LATENCY) : '0;

  always_ff @(posedge CLK) begin
    if (SYNC_RST) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (op && rows == '0) ? DONE : RD;
      RD:    if (rd_cnt == len_q - CW'(1)) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == drain_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes trail reads by a fixed delay line, so long row counts overlap reads and writes freely.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      op_q      <= 1'b0;
      len_q     <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_pipe   <= '0;
    end else begin
      wr_pipe <= {wr_pipe[RESULT_LATENCY-1:0], brden & op_q};
      if (accept) begin
        op_q      <= op;
        len_q     <= op ? CW'(rows) : CW'(SA_LENGTH);
        rd_cnt    <= '0;
        drain_cnt <= '0;
        rd_addr   <= src_addr;
        wr_addr   <= dst_addr;
      end else begin
        if (state == RD) begin
          rd_cnt  <= rd_cnt + CW'(1);
          rd_addr <= rd_addr + BW'(1);
        end
        if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
        if (bwren) wr_addr <= wr_addr + BW'(1);
      end
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    brden   = (state == RD);
    brdaddr = brden ? rd_addr : '0;
    bwren   = wr_pipe[RESULT_LATENCY];
    bwraddr = bwren ? wr_addr : '0;
    // The array consumes each read word one cycle later, then keeps stepping through drain.
    sa_en   = ((state == RD) && (rd_cnt != '0)) || (state == DRAIN);
    sa_load = sa_en && !op_q;
  end

`ifdef MATMUL_SEQ_PERF_EN
  always_ff @(posedge CLK) begin
    if (SYNC_RST)    cycle_count <= '0;
    else if (accept) cycle_count <= '0;
    else if (busy)   cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: per-cycle expected strobes are queued from
// closed-form timing and compared at the negative edge.
module tb_matmul_sequencer;
  localparam int SA = 10;
  localparam int RL = 20;

  logic       CLK = 1'b0;
  logic       SYNC_RST = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [5:0] src_addr = '0;
  logic [5:0] dst_addr = '0;
  logic [7:0] rows = '0;
  logic       busy, done, brden, bwren, sa_en, sa_load;
  logic [5:0] brdaddr, bwraddr;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] cycle_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [17:0] sb_q[$];

  matmul_sequencer #(
    .SA_LENGTH(SA), .UB_ADDR_WIDTH(4), .UB_NO_BANKS(4), .ROWS_WIDTH(8), .RESULT_LATENCY(RL)
  ) dut (
    .CLK(CLK), .SYNC_RST(SYNC_RST), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .rows(rows),
    .busy(busy), .done(done), .brden(brden), .brdaddr(brdaddr),
    .bwren(bwren), .bwraddr(bwraddr), .sa_en(sa_en), .sa_load(sa_load)
`ifdef MATMUL_SEQ_PERF_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [17:0] obs_vec();
    return {busy, done, brden, brdaddr, bwren, bwraddr, sa_en, sa_load};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fields: busy done brden brdaddr bwren bwraddr sa_en sa_load
  task automatic run_cmd(input string name, input logic o, input logic [5:0] s,
                         input logic [5:0] d, input logic [7:0] r,
                         input int pulse_at, input int rst_at);
    int dc, last;
    logic b, dn, re, we, se, sl;
    logic [5:0] ra, wa;
    dc   = (o && r == 0) ? 1 : (o ? int'(r) + RL + 2 : SA + 2);
    last = (rst_at > 0) ? rst_at + 1 : dc + 1;
    for (int c = 1; c <= last; c++) begin
      b  = (c <= dc);
      dn = (c == dc);
      if (!o) begin
        re = (c <= SA);
        se = (c >= 2) && (c <= SA + 1);
        sl = se;
        we = 1'b0;
      end else begin
        re = (c <= int'(r));
        se = (r != 0) && (c >= 2) && (c <= int'(r) + 1 + RL);
        sl = 1'b0;
        we = (c >= RL + 2) && (c <= RL + 1 + int'(r));
      end
      ra = re ? s + 6'(c - 1) : 6'd0;
      wa = we ? d + 6'(c - RL - 2) : 6'd0;
      if (rst_at > 0 && c > rst_at) sb_q.push_back('0);
      else sb_q.push_back({b, dn, re, ra, we, wa, se, sl});
    end
    start = 1'b1; op = o; src_addr = s; dst_addr = d; rows = r;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      check($sformatf("%s c=%0d", name, c), 32'(obs_vec()), 32'(sb_q.pop_front()));
      if (c == pulse_at) begin
        start = 1'b1; op = 1'b0; src_addr = 6'd50; dst_addr = 6'd1; rows = 8'd7;
      end else start = 1'b0;
      if (c == rst_at) SYNC_RST = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) SYNC_RST = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    SYNC_RST = 1'b0;
    @(negedge CLK);
    check("idle_after_reset", 32'(obs_vec()), 32'd0);

    run_cmd("load_src8",       1'b0, 6'd8,  6'd0,  8'd0,  0, 0);
    run_cmd("mm_r3",           1'b1, 6'd4,  6'd32, 8'd3,  0, 0);
    run_cmd("mm_wrap",         1'b1, 6'd62, 6'd63, 8'd4,  0, 0);
    run_cmd("mm_r0",           1'b1, 6'd9,  6'd9,  8'd0,  0, 0);
    run_cmd("mm_r30_overlap",  1'b1, 6'd40, 6'd50, 8'd30, 0, 0);
    run_cmd("load_wrap",       1'b0, 6'd60, 6'd0,  8'd0,  0, 0);
    run_cmd("mm_start_ignored",1'b1, 6'd4,  6'd32, 8'd3,  3, 0);
    run_cmd("mm_abort",        1'b1, 6'd4,  6'd32, 8'd3,  0, 5);
    @(negedge CLK);
    check("abort_idle", 32'(obs_vec()), 32'd0);
    run_cmd("load_after_abort",1'b0, 6'd8,  6'd0,  8'd0,  0, 0);
`ifdef MATMUL_SEQ_PERF_EN
    run_cmd("mm_perf",         1'b1, 6'd4,  6'd32, 8'd3,  0, 0);
    check("cycle_count_done", cycle_count, 32'd25);
    repeat (10) @(negedge CLK);
    check("cycle_count_hold", cycle_count, 32'd25);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
